vend_dispense_sched: RTL and testbench
======================================

Name: vend_dispense_sched

Overview:
- Schedules the vending machine's single shared dispense motor between four product-select requesters. Requesters are the active-low slide switches.
- Latches requests and arbitrates round-robin. Checks credit against price and slot stock, issues a charge pulse, times the motor, and drives the status LEDs and red/green/yellow lamps.
- Sits between the switch/button inputs and the dispenser and credit datapath.

Parameters:
- PRICE0, 8'd10, price of slot 0 in credit units
- PRICE1, 8'd20, price of slot 1
- PRICE2, 8'd30, price of slot 2
- PRICE3, 8'd50, price of slot 3
- MOTOR_CYC, 8, clock cycles motor_on is held per dispense (1..255)
- COOL_CYC, 4, clock cycles of post-dispense/reject lamp hold (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_n  in  4  product-select switches, active-low; bit i = slot i
- credit  in  8  current inserted credit, unsigned, stable while scheduler is busy
- slot_empty  in  4  1 = slot i out of stock
- motor_on  out  1  dispense motor drive
- motor_sel  out  2  slot index driven while motor_on
- charge_valid  out  1  one-cycle pulse: deduct charge_amt from credit
- charge_amt  out  8  price of granted slot, valid with charge_valid, else 0
- LED  out  8  {pending[3:0], grant_onehot[3:0]}
- RD  out  1  reject lamp
- GN  out  1  dispense-done lamp
- YL  out  1  busy lamp

Behaviour:
- Reset (async): state IDLE; pending=0; req_q=4'b1111; last_grant=3, so slot 0 is checked first. All outputs are 0 and LED=0.
- Reset mid-dispense drops motor_on immediately without waiting for a clock edge.
- Edge detect: req_q registers req_n. A request fires when req_q[i]=1 and req_n[i]=0.
  - The pending bit is set on the same edge, so it is visible 1 cycle after req_n is first sampled low.
  - Held-low switches fire once only.
  - Simultaneous falling edges on multiple bits set all of those bits.
- A request on an already-pending slot is absorbed; there is no depth beyond 1 per slot.
- State machine:
  - IDLE: if pending!=0, choose grant g = first set bit scanning from last_grant+1 mod 4 upward, then go to CHECK. Set last_grant=g and clear pending[g] on this edge.
  - CHECK (1 cycle, YL=1): if slot_empty[g]=1 or credit < PRICEg (unsigned 8-bit compare), this is a reject: go to COOL with RD.
    - Otherwise assert charge_valid for this cycle with charge_amt=PRICEg, and go to DISPENSE.
    - credit == PRICEg is accepted.
  - DISPENSE: motor_on=1, motor_sel=g, YL=1, for exactly MOTOR_CYC cycles (down-counter), then go to COOL with GN.
  - COOL: for exactly COOL_CYC cycles, RD=1 (reject) or GN=1 (success), YL=0, motor_on=0. Then go to IDLE.
- Grant display: grant_onehot=1<<g in CHECK/DISPENSE/COOL, otherwise 0.
- New requests, including re-requests of slot g, latch into pending in any state and are served after returning to IDLE.
- Back-to-back: IDLE→CHECK takes 1 cycle. Every service therefore costs 1 + 1 + MOTOR_CYC + COOL_CYC cycles (success) or 1 + 1 + COOL_CYC cycles (reject).
- motor_on and charge_valid are never asserted together with RD.
- Exactly one charge_valid pulse occurs per successful dispense.

Optional Feature:
- Macro: VEND_AUTO_RETRY_EN.
- Defined: a reject caused only by insufficient credit re-sets pending[g] on leaving COOL, so the slot is retried after other pending slots in round-robin order. A reject caused by slot_empty is still dropped.
- Undefined: every reject clears the request permanently.

Test Plan:
- Reset, then pulse req_n[3] low for 1 cycle with credit=60, slot_empty=0 → CHECK; charge_valid 1 cycle with charge_amt=50; motor_on=1, motor_sel=3 for 8 cycles; GN=1 for 4 cycles; LED=8'h08 while granted.
- credit=15, req_n[1] pulse → RD=1 for 4 cycles, no charge_valid, motor_on stays 0, pending[1]=0 after. With VEND_AUTO_RETRY_EN: pending[1] returns to 1 and slot 1 is rechecked.
- req_n[0] and req_n[2] fall on the same edge, credit=100 → LED[7:4]=4'b0101; slot 0 is dispensed, then slot 2; two charge pulses of 10 and 30.
- During slot-0 dispense, pulse req_n[0] and req_n[3] → after COOL, slot 3 is served before slot 0 (round-robin from last_grant=0).
- slot_empty[2]=1, credit=255, req_n[2] pulse → reject with RD, regardless of macro; not retried.
- Assert rst in cycle 3 of DISPENSE → motor_on falls asynchronously, LED=0, pending=0; a subsequent request for slot 1 is served normally.

Source files
------------

// File: rtl/vend_dispense_sched_if.sv
// vend_dispense_sched_if
//   Bundles the scheduler's switch/credit inputs and its motor, charge and lamp outputs.
//   slave  : seen by the scheduler (inputs req_n/credit/slot_empty, drives the rest).
//   master : seen by whatever drives the inputs and watches the outputs.
// Signals:
//   req_n[3:0]      product-select switches, active-low, bit i = slot i
//   credit[7:0]     inserted credit, unsigned
//   slot_empty[3:0] 1 = slot i out of stock
//   motor_on        dispense motor drive
//   motor_sel[1:0]  slot index while motor_on
//   charge_valid    one-cycle deduct pulse
//   charge_amt[7:0] price of granted slot while charge_valid, else 0
//   LED[7:0]        {pending[3:0], grant_onehot[3:0]}
//   RD / GN / YL    reject / done / busy lamps
interface vend_dispense_sched_if;
  logic [3:0] req_n;
  logic [7:0] credit;
  logic [3:0] slot_empty;
  logic       motor_on;
  logic [1:0] motor_sel;
  logic       charge_valid;
  logic [7:0] charge_amt;
  logic [7:0] LED;
  logic       RD;
  logic       GN;
  logic       YL;

  modport master (
    output req_n, credit, slot_empty,
    input  motor_on, motor_sel, charge_valid, charge_amt, LED, RD, GN, YL
  );

  modport slave (
    input  req_n, credit, slot_empty,
    output motor_on, motor_sel, charge_valid, charge_amt, LED, RD, GN, YL
  );
endinterface

// File: rtl/vend_dispense_sched.sv
// vend_dispense_sched
//   Shares one dispense motor between four product-select requesters. Falling edges on the
//   active-low switches latch into a per-slot pending bit; a round-robin pick starting after the
//   last grant selects a slot, which is checked against stock and price, charged, dispensed for
//   MOTOR_CYC cycles and followed by a COOL_CYC lamp hold.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  vend_dispense_sched_if.slave (switches, credit, stock in; motor, charge, lamps out)
// Optional build macro:
//   VEND_AUTO_RETRY_EN  when defined, a reject caused only by short credit re-queues the slot
//                       on leaving COOL; stock rejects are always dropped.
module vend_dispense_sched #(
  parameter logic [7:0]  PRICE0    = 8'd10,
  parameter logic [7:0]  PRICE1    = 8'd20,
  parameter logic [7:0]  PRICE2    = 8'd30,
  parameter logic [7:0]  PRICE3    = 8'd50,
  parameter int unsigned MOTOR_CYC = 8,
  parameter int unsigned COOL_CYC  = 4
) (
  input logic                  clk,
  input logic                  rst,
  vend_dispense_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StDispense, StCool} state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_req_q;
  logic [3:0] r_pending, w_pending_d;
  logic [1:0] r_grant, w_grant_d;      // doubles as last_grant
  logic [7:0] r_cnt, w_cnt_d;
  logic       r_reject, w_reject_d;    // COOL shows RD when set, GN otherwise
`ifdef VEND_AUTO_RETRY_EN
  logic       r_short, w_short_d;      // reject was due to credit only
`endif

  logic [3:0] w_fire;
  logic [3:0] w_clr;
  logic [3:0] w_set;
  logic [1:0] w_rr_idx;
  logic [1:0] w_cand;
  logic       w_rr_found;
  logic [7:0] w_price;
  logic       w_reject_now;
  logic [3:0] w_onehot;

  // A request fires on the first cycle the switch is seen low after being high.
  assign w_fire = r_req_q & ~bus.req_n;

  // Round-robin pick: first pending bit scanning from last_grant+1 upward, wrapping.
  always_comb begin
    w_rr_idx   = r_grant;
    w_rr_found = 1'b0;
    w_cand     = r_grant;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_grant + 2'(k);
      if (!w_rr_found && r_pending[w_cand]) begin
        w_rr_idx   = w_cand;
        w_rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_price = PRICE0;
    case (r_grant)
      2'd0:    w_price = PRICE0;
      2'd1:    w_price = PRICE1;
      2'd2:    w_price = PRICE2;
      default: w_price = PRICE3;
    endcase
  end

  // Equal credit and price is accepted.
  assign w_reject_now = bus.slot_empty[r_grant] | (bus.credit < w_price);
  assign w_onehot     = (r_state != StIdle) ? (4'b0001 << r_grant) : 4'b0000;

  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = r_grant;
    w_cnt_d    = r_cnt;
    w_reject_d = r_reject;
`ifdef VEND_AUTO_RETRY_EN
    w_short_d  = r_short;
`endif
    w_clr      = 4'b0000;
    w_set      = 4'b0000;

    bus.motor_on     = 1'b0;
    bus.motor_sel    = 2'd0;
    bus.charge_valid = 1'b0;
    bus.charge_amt   = 8'd0;
    bus.RD           = 1'b0;
    bus.GN           = 1'b0;
    bus.YL           = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (|r_pending) begin
          w_state_d = StCheck;
          w_grant_d = w_rr_idx;
          w_clr     = 4'b0001 << w_rr_idx;
        end
      end

      StCheck: begin
        bus.YL = 1'b1;
        if (w_reject_now) begin
          w_state_d  = StCool;
          w_cnt_d    = 8'(COOL_CYC);
          w_reject_d = 1'b1;
`ifdef VEND_AUTO_RETRY_EN
          w_short_d  = ~bus.slot_empty[r_grant];
`endif
        end else begin
          bus.charge_valid = 1'b1;
          bus.charge_amt   = w_price;
          w_state_d        = StDispense;
          w_cnt_d          = 8'(MOTOR_CYC);
          w_reject_d       = 1'b0;
`ifdef VEND_AUTO_RETRY_EN
          w_short_d        = 1'b0;
`endif
        end
      end

      StDispense: begin
        bus.YL        = 1'b1;
        bus.motor_on  = 1'b1;
        bus.motor_sel = r_grant;
        if (r_cnt <= 8'd1) begin
          w_state_d = StCool;
          w_cnt_d   = 8'(COOL_CYC);
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end

      StCool: begin
        bus.RD = r_reject;
        bus.GN = ~r_reject;
        if (r_cnt <= 8'd1) begin
          w_state_d = StIdle;
`ifdef VEND_AUTO_RETRY_EN
          if (r_reject && r_short) w_set = 4'b0001 << r_grant;
`endif
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // New edges latch in every state, including a re-request of the slot being granted.
  assign w_pending_d = (r_pending & ~w_clr) | w_fire | w_set;

  assign bus.LED = {r_pending, w_onehot};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_req_q   <= 4'b1111;
      r_pending <= 4'b0000;
      r_grant   <= 2'd3;
      r_cnt     <= 8'd0;
      r_reject  <= 1'b0;
`ifdef VEND_AUTO_RETRY_EN
      r_short   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_req_q   <= bus.req_n;
      r_pending <= w_pending_d;
      r_grant   <= w_grant_d;
      r_cnt     <= w_cnt_d;
      r_reject  <= w_reject_d;
`ifdef VEND_AUTO_RETRY_EN
      r_short   <= w_short_d;
`endif
    end
  end

endmodule

// File: tb/tb_vend_dispense_sched.sv
module tb_vend_dispense_sched;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vend_dispense_sched_if bus ();

  vend_dispense_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one service from its CHECK sample until the grant display clears, tallying outputs.
  // Optionally pulses req_n to inj_v for one cycle at sample index inj_n.
  task automatic observe(input int inj_n, input logic [3:0] inj_v, input logic [1:0] exp_sel,
                         output int chg, output int sum, output int mot, output int gn,
                         output int rd, output int bad);
    int n;
    n = 0; chg = 0; sum = 0; mot = 0; gn = 0; rd = 0; bad = 0;
    while (bus.LED[3:0] != 4'b0000 && n < 100) begin
      if (n == inj_n) bus.req_n = inj_v;
      else if (n == inj_n + 1) bus.req_n = 4'b1111;
      if (bus.charge_valid) begin
        chg++;
        sum += int'(bus.charge_amt);
      end
      if (bus.motor_on) begin
        mot++;
        if (bus.motor_sel != exp_sel) bad++;
      end
      if (bus.GN) gn++;
      if (bus.RD) begin
        rd++;
        if (bus.motor_on || bus.charge_valid) bad++;
      end
      step();
      n++;
    end
    if (n >= 100) bad++;
  endtask

  int chg, sum, mot, gn, rd, bad;

  initial begin
    rst            = 1'b1;
    bus.req_n      = 4'b1111;
    bus.credit     = 8'd0;
    bus.slot_empty = 4'b0000;
    #3;
    chk("rst_led", 32'(bus.LED), 32'h00);
    chk("rst_motor", 32'(bus.motor_on), 32'd0);
    chk("rst_lamps", 32'({bus.RD, bus.GN, bus.YL, bus.charge_valid}), 32'd0);
    #9 rst = 1'b0;
    step();
    chk("idle_led", 32'(bus.LED), 32'h00);

    // Single success on slot 3.
    bus.credit = 8'd60;
    bus.req_n  = 4'b0111;
    step();
    chk("t1_pending", 32'(bus.LED), 32'h80);
    bus.req_n = 4'b1111;
    step();
    chk("t1_check_led", 32'(bus.LED), 32'h08);
    chk("t1_check_yl", 32'(bus.YL), 32'd1);
    chk("t1_charge_v", 32'(bus.charge_valid), 32'd1);
    chk("t1_charge_amt", 32'(bus.charge_amt), 32'd50);
    observe(-1, 4'b1111, 2'd3, chg, sum, mot, gn, rd, bad);
    chk("t1_chg", 32'(chg), 32'd1);
    chk("t1_mot", 32'(mot), 32'd8);
    chk("t1_gn", 32'(gn), 32'd4);
    chk("t1_rd", 32'(rd), 32'd0);
    chk("t1_bad", 32'(bad), 32'd0);
    chk("t1_end_led", 32'(bus.LED), 32'h00);

    // Simultaneous 0 and 2; during slot-0 dispense re-request 0 and 3.
    bus.credit = 8'd100;
    bus.req_n  = 4'b1010;
    step();
    chk("t3_pending", 32'(bus.LED), 32'h50);
    bus.req_n = 4'b1111;
    step();
    chk("t3_check0_led", 32'(bus.LED), 32'h41);
    chk("t3_amt0", 32'(bus.charge_amt), 32'd10);
    observe(2, 4'b0110, 2'd0, chg, sum, mot, gn, rd, bad);
    chk("t3_s0", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h010a_0804);
    chk("t3_s0_bad", 32'(bad), 32'd0);
    chk("t3_after0_led", 32'(bus.LED), 32'hd0);
    step();
    chk("t3_check2_led", 32'(bus.LED), 32'h94);
    observe(-1, 4'b1111, 2'd2, chg, sum, mot, gn, rd, bad);
    chk("t3_s2", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h011e_0804);
    chk("t3_after2_led", 32'(bus.LED), 32'h90);
    step();
    chk("t4_check3_led", 32'(bus.LED), 32'h18);
    observe(-1, 4'b1111, 2'd3, chg, sum, mot, gn, rd, bad);
    chk("t4_s3", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h0132_0804);
    chk("t4_after3_led", 32'(bus.LED), 32'h10);
    step();
    chk("t4_check0_led", 32'(bus.LED), 32'h01);
    observe(-1, 4'b1111, 2'd0, chg, sum, mot, gn, rd, bad);
    chk("t4_s0", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h010a_0804);
    chk("t4_bad", 32'(bad), 32'd0);
    chk("t4_end_led", 32'(bus.LED), 32'h00);

    // Credit-short reject on slot 1.
    bus.credit = 8'd15;
    bus.req_n  = 4'b1101;
    step();
    chk("t2_pending", 32'(bus.LED), 32'h20);
    bus.req_n = 4'b1111;
    step();
    chk("t2_check_led", 32'(bus.LED), 32'h02);
    chk("t2_check_cv", 32'(bus.charge_valid), 32'd0);
    observe(-1, 4'b1111, 2'd1, chg, sum, mot, gn, rd, bad);
    chk("t2_tally", 32'({chg[7:0], mot[7:0], gn[7:0], rd[7:0]}), 32'h0000_0004);
    chk("t2_bad", 32'(bad), 32'd0);
`ifdef VEND_AUTO_RETRY_EN
    chk("t2_retry_led", 32'(bus.LED), 32'h20);
    bus.credit = 8'd100;
    step();
    chk("t2_recheck_led", 32'(bus.LED), 32'h02);
    observe(-1, 4'b1111, 2'd1, chg, sum, mot, gn, rd, bad);
    chk("t2_retry_s1", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h0114_0804);
`endif
    chk("t2_end_led", 32'(bus.LED), 32'h00);

    // Empty slot 2 with ample credit: rejected and never retried.
    bus.credit     = 8'd255;
    bus.slot_empty = 4'b0100;
    bus.req_n      = 4'b1011;
    step();
    chk("t5_pending", 32'(bus.LED), 32'h40);
    bus.req_n = 4'b1111;
    step();
    chk("t5_check_led", 32'(bus.LED), 32'h04);
    observe(-1, 4'b1111, 2'd2, chg, sum, mot, gn, rd, bad);
    chk("t5_tally", 32'({chg[7:0], mot[7:0], gn[7:0], rd[7:0]}), 32'h0000_0004);
    chk("t5_end_led", 32'(bus.LED), 32'h00);
    bus.slot_empty = 4'b0000;

    // Reset asserted mid-dispense, away from a clock edge.
    bus.credit = 8'd100;
    bus.req_n  = 4'b0111;
    step();
    bus.req_n = 4'b1111;
    step();
    chk("t6_check_led", 32'(bus.LED), 32'h08);
    step();
    bus.req_n = 4'b1110;
    step();
    bus.req_n = 4'b1111;
    step();
    chk("t6_disp3_motor", 32'(bus.motor_on), 32'd1);
    chk("t6_disp3_led", 32'(bus.LED), 32'h18);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_motor", 32'(bus.motor_on), 32'd0);
    chk("t6_async_led", 32'(bus.LED), 32'h00);
    chk("t6_async_yl", 32'(bus.YL), 32'd0);
    #1 rst = 1'b0;
    step();
    chk("t6_idle_led", 32'(bus.LED), 32'h00);
    bus.req_n = 4'b1101;
    step();
    chk("t6_pending1", 32'(bus.LED), 32'h20);
    bus.req_n = 4'b1111;
    step();
    chk("t6_check1_led", 32'(bus.LED), 32'h02);
    observe(-1, 4'b1111, 2'd1, chg, sum, mot, gn, rd, bad);
    chk("t6_s1", 32'({chg[7:0], sum[7:0], mot[7:0], gn[7:0]}), 32'h0114_0804);
    chk("t6_bad", 32'(bad + rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
